// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-deep FIFO with synchronous flush; used for the pending-address queue
// and for the presented-instruction buffer.
module fetch_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      // contents are left in place; only the occupancy is discarded
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch with 2-credit flow control and redirect flush.
//   state | meaning
//   FETCH | issue requests while credit remains, buffer responses
//   FLUSH | no requests; discard drop_cnt stale responses after a redirect
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  state_e              state_q, state_d;
  logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
  logic [1:0]          drop_cnt_q, drop_cnt_d;
  logic [1:0]          out_cnt, buf_cnt;
  logic                req_accept, rsp_live;
  logic                pend_push, pend_pop, obuf_push, obuf_pop;
  logic [XLEN-1:0]     pend_head;
  logic [2*XLEN-1:0]   obuf_head;
  logic [2:0]          stale_cnt;

  assign imem_req   = rst_n && (state_q == FETCH) &&
                      (({1'b0, out_cnt} + {1'b0, buf_cnt}) < 3'd2);
  assign imem_addr  = fetch_pc_q;
  assign req_accept = imem_req && imem_gnt;

  // A response only counts if something is actually waiting for it.
  assign rsp_live = imem_rvalid &&
                    (((state_q == FETCH) && (out_cnt != 2'd0)) ||
                     ((state_q == FLUSH) && (drop_cnt_q != 2'd0)));

  assign pend_push = req_accept && !redirect_valid;
  assign pend_pop  = rsp_live && (state_q == FETCH) && !redirect_valid;
  assign obuf_push = pend_pop;
  assign obuf_pop  = valid && !hold;

  // Every response still owed by memory becomes stale on a redirect,
  // minus the one being delivered (and discarded) this very cycle.
  assign stale_cnt = {1'b0, drop_cnt_q} + {1'b0, out_cnt} +
                     {2'b00, req_accept} - {2'b00, rsp_live};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (req_accept) begin
      fetch_pc_d = fetch_pc_q + PC_INC;
    end
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      drop_cnt_d = stale_cnt[1:0];
      state_d    = (stale_cnt != 3'd0) ? FLUSH : FETCH;
    end else if (state_q == FLUSH) begin
      if (drop_cnt_q == 2'd0) begin
        state_d = FETCH;
      end else if (rsp_live) begin
        drop_cnt_d = drop_cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN)) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (pend_push),
    .wdata (fetch_pc_q),
    .pop   (pend_pop),
    .rdata (pend_head),
    .count (out_cnt)
  );

  fetch_fifo #(.WIDTH(2*XLEN)) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (obuf_push),
    .wdata ({pend_head, imem_rdata}),
    .pop   (obuf_pop),
    .rdata (obuf_head),
    .count (buf_cnt)
  );

  assign valid = (buf_cnt != 2'd0);
  assign pc    = obuf_head[2*XLEN-1:XLEN];
  assign instr = obuf_head[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with programmable latency and
// a scoreboard of expected pc/instr pairs consumed from the output.
module tb_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid;
  logic [31:0] pc, instr;

  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = 32'h0;
  logic        valid2;
  logic [31:0] pc2, instr2;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid(valid), .pc(pc), .instr(instr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .hold(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .valid(valid2), .pc(pc2), .instr(instr2)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] + 16'h1357};
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] issued_q[$];
  logic [31:0] issued2_q[$];
  int          mem_lat = 1;
  int          cyc = 0;
  int          n_issued = 0;
  int          n_consumed = 0;
  logic [31:0] e;

  // memory model + scoreboard for the main instance
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_q.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(rsp_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    imem_gnt = 1'b1;
    #1;
    if (rst_n && imem_req && imem_gnt) begin
      rsp_q.push_back('{addr: imem_addr, due: cyc + mem_lat});
      issued_q.push_back(imem_addr);
      n_issued++;
    end
    if (imem_rvalid) void'(rsp_q.pop_front());
    if (rst_n && valid && !hold) begin
      n_consumed++;
      if (exp_q.size() == 0) begin
        chk("sb_extra", 32'(valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", pc, e);
        chk("sb_instr", instr, mem_word(e));
      end
    end
    cyc++;
  end

  // 1-cycle memory for the wrap instance
  logic        acc2_prev = 1'b0;
  logic [31:0] addr2_prev = 32'h0;
  logic        wrap_seen = 1'b0;
  logic [31:0] wrap_pc = 32'h0, wrap_instr = 32'h0;

  always @(negedge clk) begin
    rvalid2 = rst_n && acc2_prev;
    rdata2  = mem_word(addr2_prev);
    #1;
    acc2_prev  = rst_n && req2;
    addr2_prev = addr2;
    if (rst_n && req2) issued2_q.push_back(addr2);
    if (rst_n && valid2 && !wrap_seen) begin
      wrap_seen  = 1'b1;
      wrap_pc    = pc2;
      wrap_instr = instr2;
    end
  end

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst_n = 1'b0;
    hold = 1'b0;
    redirect_valid = 1'b0;
    mem_lat = lat;
    repeat (2) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    issued_q.delete();
    issued2_q.delete();
    n_issued = 0;
    n_consumed = 0;
    wrap_seen = 1'b0;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    hold = 1'b1;
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid_then_hold(input string tag);
    int n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (valid) break;
    end
    hold = 1'b1;
    chk({tag, "_valid_seen"}, 32'(valid), 32'd1);
  endtask

  int req_seen;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req_wrap", 32'(req2), 32'd0);

    // first fetches and latency
    push_seq(32'h0, 6);
    release_rst();
    @(negedge clk);
    #2;
    chk("A_valid_before_rsp", 32'(valid), 32'd0);
    chk("A_rvalid", 32'(imem_rvalid), 32'd1);
    @(negedge clk);
    #2;
    chk("A_first_valid", 32'(valid), 32'd1);
    chk("A_first_pc", pc, 32'h0);
    chk("A_first_instr", instr, mem_word(32'h0));
    drain("A", 60);
    chk("A_n_issued", 32'(issued_q.size() >= 3), 32'd1);
    if (issued_q.size() >= 3) begin
      chk("A_addr0", issued_q[0], 32'h0);
      chk("A_addr1", issued_q[1], 32'h4);
      chk("A_addr2", issued_q[2], 32'h8);
    end
    chk("W_n_issued", 32'(issued2_q.size() >= 3), 32'd1);
    if (issued2_q.size() >= 3) begin
      chk("W_addr0", issued2_q[0], 32'hFFFF_FFF8);
      chk("W_addr1", issued2_q[1], 32'hFFFF_FFFC);
      chk("W_addr2", issued2_q[2], 32'h0000_0000);
    end
    chk("W_seen", 32'(wrap_seen), 32'd1);
    chk("W_pc", wrap_pc, 32'hFFFF_FFF8);
    chk("W_instr", wrap_instr, mem_word(32'hFFFF_FFF8));

    // hold back-pressure
    do_reset(1);
    push_seq(32'h0, 6);
    release_rst();
    wait_valid_then_hold("B");
    repeat (4) @(negedge clk);
    #2;
    chk("B_hold_req", 32'(imem_req), 32'd0);
    chk("B_hold_issued", 32'(n_issued), 32'd2);
    chk("B_hold_consumed", 32'(n_consumed), 32'd0);
    chk("B_hold_valid", 32'(valid), 32'd1);
    @(negedge clk);
    hold = 1'b0;
    drain("B", 60);

    // redirect with two requests outstanding
    do_reset(3);
    push_seq(32'h100, 3);
    release_rst();
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    #2;
    chk("C_outstanding", 32'(n_issued), 32'd2);
    chk("C_req_at_redir", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    chk("C_valid_after_redir", 32'(valid), 32'd0);
    req_seen = 32'(imem_req);
    repeat (2) begin
      @(negedge clk);
      #2;
      req_seen += 32'(imem_req);
    end
    chk("C_flush_no_req", 32'(req_seen), 32'd0);
    drain("C", 60);
    chk("C_n_issued", 32'(issued_q.size() >= 3), 32'd1);
    if (issued_q.size() >= 3) chk("C_addr_target", issued_q[2], 32'h100);

    // redirect coincident with grant and response, misaligned target
    do_reset(1);
    push_seq(32'h200, 3);
    release_rst();
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    #2;
    chk("D_coinc_req", 32'(imem_req), 32'd1);
    chk("D_coinc_rvalid", 32'(imem_rvalid), 32'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    chk("D_valid_after_redir", 32'(valid), 32'd0);
    drain("D", 60);
    chk("D_n_issued", 32'(issued_q.size() >= 3), 32'd1);
    if (issued_q.size() >= 3) chk("D_addr_target", issued_q[2], 32'h200);

    // reset mid-stream with a full buffer
    do_reset(1);
    push_seq(32'h0, 8);
    release_rst();
    wait_valid_then_hold("E");
    repeat (3) @(negedge clk);
    #2;
    chk("E_full_outstanding", 32'(n_issued - n_consumed), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #2;
    chk("E_rst_valid", 32'(valid), 32'd0);
    chk("E_rst_req", 32'(imem_req), 32'd0);
    chk("E_rst_pc", pc, 32'h0);
    chk("E_rst_instr", instr, 32'h0);
    push_seq(32'h0, 4);
    hold = 1'b0;
    release_rst();
    drain("E", 60);
    chk("E_n_issued", 32'(issued_q.size() >= 1), 32'd1);
    if (issued_q.size() >= 1) chk("E_restart_addr", issued_q[0], 32'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
